stopwatch_bcd: RTL

- Consumes the periodic one-cycle tick from the clock-tick generator, configured for 0.1 s, and keeps an MM:SS.t elapsed time in BCD.
- Provides start/stop/clear/lap control through a small FSM.
- Outputs feed the seven-segment display mux directly, one 4-bit BCD digit per position.

---
 rtl/stopwatch_bcd.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.t elapsed-time counter in BCD driven by a 0.1 s tick.
// A three-state FSM (IDLE/RUN/PAUSE) gates counting; lap freezes the display
// on a snapshot while the live counter keeps going underneath.
//
// Command interface: start/stop/clear/lap are single-cycle pulses sampled on
// every rising clk edge; there is no handshake and no back-pressure, so a
// pulse held for N cycles acts as N commands. Within one edge the priority is
// clear > stop > start, and lap is resolved separately unless clear is high.
module stopwatch_bcd #(
    parameter int MAX_MIN        = 59,
    parameter int TENTHS_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] d_tenth,
    output logic [3:0] d_sec0,
    output logic [3:0] d_sec1,
    output logic [3:0] d_min0,
    output logic [3:0] d_min1,
    output logic       running,
    output logic       lap_held,
    output logic       wrap,
    output logic [1:0] dbg_state
);

    // Reject parameter values the digit logic cannot represent.
    generate
        if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max_min
            $error("stopwatch_bcd: MAX_MIN must be in 1..99");
        end
        if (TENTHS_PER_SEC < 2 || TENTHS_PER_SEC > 10) begin : g_bad_tenths
            $error("stopwatch_bcd: TENTHS_PER_SEC must be in 2..10");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [3:0] T_LAST    = 4'(TENTHS_PER_SEC - 1);
    localparam logic [3:0] MIN1_LAST = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN0_LAST = 4'(MAX_MIN % 10);

    logic [1:0] state, state_nx;

    // Live counter digits and their next values.
    logic [3:0] tenth, sec0, sec1, min0, min1;
    logic [3:0] t_nx, s0_nx, s1_nx, m0_nx, m1_nx;

    // Lap snapshot digits.
    logic [3:0] snap_tenth, snap_sec0, snap_sec1, snap_min0, snap_min1;

    logic inc;
    logic roll;
    logic take_snap;
    logic lap_held_nx;

    assign dbg_state = state;

    // Next-state logic; stop suppresses a same-cycle start, clear beats both.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && !stop) state_nx = S_RUN;
            S_RUN:   if (stop) state_nx = S_PAUSE;
            S_PAUSE: if (start && !stop) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
        if (clear) state_nx = S_IDLE;
    end

    // Counting depends on the current state only, so a tick with start is
    // dropped and a tick with stop is still counted.
    assign inc = (state == S_RUN) && tick;

    // Single-edge digit cascade; every carry is resolved combinationally.
    always_comb begin
        t_nx  = tenth;
        s0_nx = sec0;
        s1_nx = sec1;
        m0_nx = min0;
        m1_nx = min1;
        roll  = 1'b0;
        if (inc) begin
            if (tenth != T_LAST) begin
                t_nx = tenth + 4'd1;
            end else begin
                t_nx = 4'd0;
                if (sec0 != 4'd9) begin
                    s0_nx = sec0 + 4'd1;
                end else begin
                    s0_nx = 4'd0;
                    if (sec1 != 4'd5) begin
                        s1_nx = sec1 + 4'd1;
                    end else begin
                        s1_nx = 4'd0;
                        if (min1 == MIN1_LAST && min0 == MIN0_LAST) begin
                            m0_nx = 4'd0;
                            m1_nx = 4'd0;
                            roll  = 1'b1;
                        end else if (min0 != 4'd9) begin
                            m0_nx = min0 + 4'd1;
                        end else begin
                            m0_nx = 4'd0;
                            m1_nx = min1 + 4'd1;
                        end
                    end
                end
            end
        end
        if (clear) begin
            t_nx  = 4'd0;
            s0_nx = 4'd0;
            s1_nx = 4'd0;
            m0_nx = 4'd0;
            m1_nx = 4'd0;
            roll  = 1'b0;
        end
    end

    // Lap decision: release works in any state, capture only while running.
    always_comb begin
        take_snap   = 1'b0;
        lap_held_nx = lap_held;
        if (clear) begin
            lap_held_nx = 1'b0;
        end else if (lap) begin
            if (lap_held) begin
                lap_held_nx = 1'b0;
            end else if (state == S_RUN) begin
                lap_held_nx = 1'b1;
                take_snap   = 1'b1;
            end
        end
    end

    // State, live digits and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tenth    <= 4'd0;
            sec0     <= 4'd0;
            sec1     <= 4'd0;
            min0     <= 4'd0;
            min1     <= 4'd0;
            running  <= 1'b0;
            lap_held <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_nx;
            tenth    <= t_nx;
            sec0     <= s0_nx;
            sec1     <= s1_nx;
            min0     <= m0_nx;
            min1     <= m1_nx;
            running  <= (state_nx == S_RUN);
            lap_held <= lap_held_nx;
            wrap     <= roll;
        end
    end

    // Snapshot captures the post-increment value of the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_tenth <= 4'd0;
            snap_sec0  <= 4'd0;
            snap_sec1  <= 4'd0;
            snap_min0  <= 4'd0;
            snap_min1  <= 4'd0;
        end else if (take_snap) begin
            snap_tenth <= t_nx;
            snap_sec0  <= s0_nx;
            snap_sec1  <= s1_nx;
            snap_min0  <= m0_nx;
            snap_min1  <= m1_nx;
        end
    end

    // Display mux: frozen snapshot while held, live digits otherwise.
    always_comb begin
        if (lap_held) begin
            d_tenth = snap_tenth;
            d_sec0  = snap_sec0;
            d_sec1  = snap_sec1;
            d_min0  = snap_min0;
            d_min1  = snap_min1;
        end else begin
            d_tenth = tenth;
            d_sec0  = sec0;
            d_sec1  = sec1;
            d_min0  = min0;
            d_min1  = min1;
        end
    end

endmodule
